prop_checker_array: RTL
=======================

// Module: prop_checker_array
// PURPOSE
//  Synthesizable multi-channel temporal property checker: each channel checks "antecedent implies consequent N cycles later".
//  Checks are exact-delay, windowed or forbidden. Configurable delay, error counting and first-failure capture.
//  Sits beside the cache datapath (AXI handshakes, fill/evict pairs) so property failures are visible in silicon and in emulation.
// PARAMETERS
//  NUM_CH   4   number of independent check channels
//  MAX_DLY  8   largest supported check delay in cycles (>=1)
//  CNT_W    16  width of each per-channel error counter
//  DLY_W    $clog2(MAX_DLY+1)  derived; width of a delay field
// PORTS
//  clk            in   1              clock, all logic on posedge
//  reset          in   1              synchronous, active-high reset
//  enable         in   1              global check enable
//  clear          in   1              clears sticky flags, counters, first-error capture
//  cfg_mode       in   2*NUM_CH       per channel: 00 FIXED, 01 WINDOW, 10 NEVER, 11 OFF
//  cfg_dly        in   DLY_W*NUM_CH   per-channel delay D, 0..MAX_DLY; values >MAX_DLY are clamped to MAX_DLY
//  ante           in   NUM_CH         antecedent per channel
//  cons           in   NUM_CH         consequent per channel
//  err_pulse      out  NUM_CH         1-cycle pulse per failure
//  err_sticky     out  NUM_CH         set on failure, held until clear/reset
//  err_cnt        out  CNT_W*NUM_CH   saturating failure count per channel
//  first_valid    out  1              a first failure has been captured
//  first_ch       out  $clog2(NUM_CH) channel of first captured failure
// BEHAVIOUR
//  - Reset: all outputs 0, all pending obligations flushed. Reset wins over every other input.
//  - Obligation: ante[i]=1 with enable=1 at cycle t, mode!=OFF, starts an obligation.
//    Each channel holds a MAX_DLY-deep pending shift register, so overlapping obligations are tracked independently.
//  - FIXED: fails if cons[i]=0 at cycle t+D.
//  - WINDOW: fails if cons[i] is 0 on every cycle t..t+D. Any cons[i]=1 discharges all pending obligations on that channel.
//  - NEVER: fails if cons[i]=1 at cycle t+D.
//  - D=0: check is on the same cycle as ante.
//  - Latency: a failure evaluated at cycle c gives err_pulse[i]=1 at c+1. err_sticky and err_cnt update at c+1.
//  - enable=0: no new obligations. All pending obligations are flushed in the same cycle, with no error (disable-iff semantics).
//  - Config change: any change in cfg_mode[i]/cfg_dly[i] vs the previous cycle flushes channel i pending, with no error.
//    An ante in that same cycle starts an obligation under the new config.
//  - err_cnt saturates at 2^CNT_W-1; no wrap.
//  - clear with a simultaneous failure: sticky=1, cnt=1 next cycle. err_pulse is unaffected by clear.
//  - first_valid/first_ch: load on the first failure after reset/clear.
//    Among simultaneous failures the lowest channel index wins. Held until clear/reset.
//    A clear with a simultaneous failure captures that failure.
//  - Multiple obligations maturing in one cycle on one channel count as one failure; err_cnt increments by 1.
// CONFIGURATION
//  PROP_CHECKER_TIMESTAMP_EN defined:
//    - Adds a free-running 32-bit cycle counter (0 at reset, wraps).
//    - Adds output port first_time [31:0], which holds the counter value at the failing evaluation cycle, captured together with first_ch.
//  Undefined: no counter and no first_time port. All other behaviour is identical.
// TESTING
//  1 FIXED D=3 ch0: ante@10, cons@13=1 -> no error. ante@20, cons@23=0 -> err_pulse[0]@24, err_cnt0=1, first_ch=0.
//  2 WINDOW D=4 ch1: ante@5,6,7, single cons@9 -> no error. ante@30, no cons through 34 -> one pulse@35.
//  3 NEVER D=0 ch2: ante=cons=1@8 -> err_pulse[2]@9. Same cycle failure on ch3 -> first_ch=2.
//  4 FIXED D=2 ch0: ante@10, enable=0@11 -> no error at 13. cfg_dly change @11 with pending -> flushed, no error.
//  5 CNT_W=2: 5 failures on ch0 -> err_cnt0 sticks at 3. clear with concurrent failure -> cnt=1, sticky=1.
//  6 Reset @12 with 3 pending obligations -> outputs 0 @13, no errors ever raised for them.
//    With PROP_CHECKER_TIMESTAMP_EN: first_time equals the failing cycle count.

Source files
------------

// File: rtl/prop_checker_array.sv
// -----------------------------------------------------------------------------
// prop_checker_array
//   Multi-channel temporal property checker. Every channel checks that an
//   antecedent is followed by the expected consequent behaviour D cycles later:
//     FIXED  (00) : cons must be 1 exactly D cycles after ante
//     WINDOW (01) : cons must be 1 on at least one cycle of t..t+D
//     NEVER  (10) : cons must be 0 exactly D cycles after ante
//     OFF    (11) : channel ignored
//   Failures raise a one-cycle pulse, a sticky flag and a saturating counter.
//   The first failure after reset/clear is captured (lowest channel wins).
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   enable              global enable; low flushes all pending obligations
//   clear               clears sticky flags, counters and first-failure capture
//   cfg_mode, cfg_dly   per-channel mode (2 bits) and delay (DLY_W bits)
//   ante, cons          per-channel antecedent / consequent
//   err_pulse           per-channel failure pulse (one cycle after evaluation)
//   err_sticky          per-channel sticky failure flag
//   err_cnt             per-channel saturating failure count
//   first_valid         a first failure has been captured
//   first_ch            channel of the captured first failure
//   first_time          (PROP_CHECKER_TIMESTAMP_EN only) cycle counter value
//                       at the evaluation cycle of the captured failure
//
// Build option
//   PROP_CHECKER_TIMESTAMP_EN : adds a free-running 32-bit cycle counter and
//                               the first_time output.
// -----------------------------------------------------------------------------
module prop_checker_array #(
    parameter int NUM_CH  = 4,
    parameter int MAX_DLY = 8,
    parameter int CNT_W   = 16,
    parameter int DLY_W   = $clog2(MAX_DLY + 1),
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [2*NUM_CH-1:0]       cfg_mode,
    input  logic [DLY_W*NUM_CH-1:0]   cfg_dly,
    input  logic [NUM_CH-1:0]         ante,
    input  logic [NUM_CH-1:0]         cons,
    output logic [NUM_CH-1:0]         err_pulse,
    output logic [NUM_CH-1:0]         err_sticky,
    output logic [CNT_W*NUM_CH-1:0]   err_cnt,
    output logic                      first_valid,
`ifdef PROP_CHECKER_TIMESTAMP_EN
    output logic [CH_W-1:0]           first_ch,
    output logic [31:0]               first_time
`else
    output logic [CH_W-1:0]           first_ch
`endif
);

    localparam logic [1:0]       MODE_FIXED  = 2'b00;
    localparam logic [1:0]       MODE_WINDOW = 2'b01;
    localparam logic [1:0]       MODE_NEVER  = 2'b10;
    localparam logic [1:0]       MODE_OFF    = 2'b11;
    localparam logic [DLY_W-1:0] DLY_CLAMP   = DLY_W'(MAX_DLY);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);

    // Previous-cycle configuration, used to detect config changes.
    logic [2*NUM_CH-1:0]     cfg_mode_q;
    logic [DLY_W*NUM_CH-1:0] cfg_dly_q;

    // pend_q[ch][a] = an open obligation started a cycles ago.
    logic [MAX_DLY:1] pend_q [NUM_CH];
    logic [MAX_DLY:1] pend_d [NUM_CH];
    logic [NUM_CH-1:0] fail_s;

    logic [NUM_CH-1:0] err_pulse_q;
    logic [NUM_CH-1:0] err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]  err_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  err_cnt_d [NUM_CH];
    logic              first_valid_q, first_valid_d;
    logic [CH_W-1:0]   first_ch_q, first_ch_d;
    logic [CH_W-1:0]   low_ch_s;
`ifdef PROP_CHECKER_TIMESTAMP_EN
    logic [31:0]       ts_q;
    logic [31:0]       first_time_q, first_time_d;
`endif

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        logic [1:0]       mode_s;
        logic [DLY_W-1:0] dly_raw_s;
        logic [DLY_W-1:0] dly_s;
        logic             chg_s;
        logic             start_s;
        logic             mature_s;
        logic             fail_ch_s;
        logic [MAX_DLY:1] live_s;
        logic [MAX_DLY:1] nxt_s;

        assign mode_s    = cfg_mode[2*g +: 2];
        assign dly_raw_s = cfg_dly[DLY_W*g +: DLY_W];

        // Per-channel evaluation: clamp delay, flush, detect failure, age obligations.
        always_comb begin
            dly_s   = (dly_raw_s > DLY_CLAMP) ? DLY_CLAMP : dly_raw_s;
            chg_s   = (mode_s != cfg_mode_q[2*g +: 2]) ||
                      (dly_raw_s != cfg_dly_q[DLY_W*g +: DLY_W]);
            start_s = enable && ante[g] && (mode_s != MODE_OFF);
            // Disable or config change drops old obligations silently; a
            // same-cycle ante still starts under the new config.
            live_s  = (enable && !chg_s) ? pend_q[g] : '0;

            if (dly_s == '0) begin
                mature_s = start_s;
            end else begin
                mature_s = live_s[dly_s];
            end

            case (mode_s)
                MODE_FIXED:  fail_ch_s = mature_s && !cons[g];
                MODE_WINDOW: fail_ch_s = mature_s && !cons[g];
                MODE_NEVER:  fail_ch_s = mature_s &&  cons[g];
                default:     fail_ch_s = 1'b0;
            endcase

            // Age obligations; those reaching age D are resolved this cycle.
            nxt_s    = '0;
            nxt_s[1] = start_s && (dly_s != '0);
            for (int a = 1; a < MAX_DLY; a++) begin
                if (a < int'(dly_s)) begin
                    nxt_s[a+1] = live_s[a];
                end else begin
                    nxt_s[a+1] = 1'b0;
                end
            end
            // A consequent in WINDOW mode discharges everything open.
            if ((mode_s == MODE_WINDOW) && cons[g]) begin
                nxt_s = '0;
            end else begin
                nxt_s = nxt_s;
            end
        end

        assign fail_s[g] = fail_ch_s;
        assign pend_d[g] = nxt_s;
        assign err_cnt[CNT_W*g +: CNT_W] = err_cnt_q[g];
    end

    // Failure bookkeeping: sticky flags, counters, first-failure capture.
    always_comb begin
        low_ch_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            low_ch_s = fail_s[i] ? CH_W'(i) : low_ch_s;
        end

        if (clear) begin
            err_sticky_d = fail_s;
        end else begin
            err_sticky_d = err_sticky_q | fail_s;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (clear) begin
                err_cnt_d[i] = fail_s[i] ? CNT_ONE : '0;
            end else if (fail_s[i] && (err_cnt_q[i] != CNT_MAX)) begin
                err_cnt_d[i] = err_cnt_q[i] + CNT_ONE;
            end else begin
                err_cnt_d[i] = err_cnt_q[i];
            end
        end

`ifdef PROP_CHECKER_TIMESTAMP_EN
        first_time_d = first_time_q;
`endif
        if (clear || (!first_valid_q && (|fail_s))) begin
            first_valid_d = |fail_s;
            first_ch_d    = low_ch_s;
`ifdef PROP_CHECKER_TIMESTAMP_EN
            first_time_d  = (|fail_s) ? ts_q : 32'd0;
`endif
        end else begin
            first_valid_d = first_valid_q;
            first_ch_d    = first_ch_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_mode_q    <= '0;
            cfg_dly_q     <= '0;
            err_pulse_q   <= '0;
            err_sticky_q  <= '0;
            first_valid_q <= 1'b0;
            first_ch_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i]    <= '0;
                err_cnt_q[i] <= '0;
            end
`ifdef PROP_CHECKER_TIMESTAMP_EN
            ts_q          <= 32'd0;
            first_time_q  <= 32'd0;
`endif
        end else begin
            cfg_mode_q    <= cfg_mode;
            cfg_dly_q     <= cfg_dly;
            err_pulse_q   <= fail_s;
            err_sticky_q  <= err_sticky_d;
            first_valid_q <= first_valid_d;
            first_ch_q    <= first_ch_d;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i]    <= pend_d[i];
                err_cnt_q[i] <= err_cnt_d[i];
            end
`ifdef PROP_CHECKER_TIMESTAMP_EN
            ts_q          <= ts_q + 32'd1;
            first_time_q  <= first_time_d;
`endif
        end
    end

    assign err_pulse   = err_pulse_q;
    assign err_sticky  = err_sticky_q;
    assign first_valid = first_valid_q;
    assign first_ch    = first_ch_q;
`ifdef PROP_CHECKER_TIMESTAMP_EN
    assign first_time  = first_time_q;
`endif

endmodule
